// File: rtl/hdmi_stream_sender.sv
// Address generator for one HDMI test-pattern stream: walks [base_addr, base_addr+length-1]
// with a valid/rdy handshake, optional looping, idle gaps between beats and abort.
module hdmi_stream_sender #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned GAP_W     = 8,
    parameter int unsigned PASS_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE-1:0] length,
    input  logic [GAP_W-1:0]     gap_cycles,
    input  logic                 rdy,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 valid,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic [PASS_W-1:0]    pass_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   beat_q, beat_d;
    logic [ADDR_SIZE-1:0]   base_q, base_d;
    logic [ADDR_SIZE-1:0]   len_q, len_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [GAP_W-1:0]       gcnt_q, gcnt_d;
    logic                   loop_q, loop_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic                   done_q, done_d;

    logic                   is_last;
    logic                   xfer;
    logic                   run_continues;

    assign is_last  = (beat_q == len_q - ADDR_SIZE'(1));
    assign valid    = (state_q == SEND);
    assign last     = valid & is_last;
    assign xfer     = valid & rdy;
    assign busy     = (state_q != IDLE);
    assign addr     = addr_q;
    assign done     = done_q;
    assign pass_cnt = pass_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        base_d        = base_q;
        len_d         = len_q;
        gap_d         = gap_q;
        gcnt_d        = gcnt_q;
        loop_d        = loop_q;
        pass_d        = pass_q;
        done_d        = 1'b0;
        run_continues = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        base_d  = base_addr;
                        len_d   = length;
                        gap_d   = gap_cycles;
                        loop_d  = loop_en;
                        addr_d  = base_addr;
                        beat_d  = '0;
                        gcnt_d  = '0;
                        pass_d  = '0;
                        state_d = SEND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            SEND: begin
                if (xfer) begin
                    if (is_last) begin
                        pass_d = pass_q + PASS_W'(1);
                        if (loop_q) begin
                            addr_d        = base_q;
                            beat_d        = '0;
                            run_continues = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = ~stop;
                        end
                    end else begin
                        addr_d        = addr_q + ADDR_SIZE'(1);
                        beat_d        = beat_q + ADDR_SIZE'(1);
                        run_continues = 1'b1;
                    end
                end
                // stop overrides both the gap and the done pulse; an accepted beat still counts
                if (stop) begin
                    state_d = IDLE;
                end else if (run_continues && (gap_q != '0)) begin
                    state_d = GAP;
                    gcnt_d  = gap_q;
                end
            end

            GAP: begin
                gcnt_d = gcnt_q - GAP_W'(1);
                if (stop) begin
                    state_d = IDLE;
                end else if (gcnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            base_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            loop_q  <= 1'b0;
            pass_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            loop_q  <= loop_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_hdmi_stream_sender.sv
// Directed bench for hdmi_stream_sender: one task per scenario, expected values written out by hand.
module tb_hdmi_stream_sender;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [31:0] base_addr;
    logic [31:0] length;
    logic [7:0]  gap_cycles;
    logic        rdy;
    logic [31:0] addr;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
    logic [15:0] pass_cnt;

    int errors = 0;
    int checks = 0;

    hdmi_stream_sender #(
        .ADDR_SIZE(32),
        .GAP_W    (8),
        .PASS_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .base_addr (base_addr),
        .length    (length),
        .gap_cycles(gap_cycles),
        .rdy       (rdy),
        .addr      (addr),
        .valid     (valid),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; on return the first beat should be offered.
    task automatic start_run(input logic [31:0] b, input logic [31:0] l,
                             input logic [7:0] g, input logic lp);
        base_addr  = b;
        length     = l;
        gap_cycles = g;
        loop_en    = lp;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; rdy = 1'b0;
        base_addr = '0; length = '0; gap_cycles = '0;
        tick(); tick();
        checks++;
        if ({addr, valid, last, busy, done, pass_cnt} !== 52'h0) begin
            errors++;
            $display("FAIL reset_state: addr=%h valid=%b last=%b busy=%b done=%b pass=%0d, required all zero",
                     addr, valid, last, busy, done, pass_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        rdy = 1'b1;
        start_run(32'h10, 32'd4, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || addr !== 32'h10 + i || last !== (i == 3) || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b addr=%h last=%b done=%b, required 1 %h %b 0",
                         i, valid, addr, last, done, 32'h10 + i, (i == 3));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || pass_cnt !== 16'd1 || addr !== 32'h13) begin
            errors++;
            $display("FAIL basic_done: done=%b valid=%b busy=%b pass=%0d addr=%h, required 1 0 0 1 00000013",
                     done, valid, busy, pass_cnt, addr);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b, required 0", done);
        end
    endtask

    task automatic test_rdy_toggle();
        int k = 0;
        int c = 0;
        rdy = 1'b0;
        start_run(32'h10, 32'd4, 8'd0, 1'b0);
        while (k < 4 && c < 30) begin
            rdy = (c % 3 == 0);
            checks++;
            if (valid !== 1'b1 || addr !== 32'h10 + k) begin
                errors++;
                $display("FAIL toggle_c%0d: valid=%b addr=%h, required 1 %h", c, valid, addr, 32'h10 + k);
            end
            tick();
            if (rdy) k++;
            c++;
        end
        rdy = 1'b0;
        checks++;
        if (k != 4 || done !== 1'b1 || pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL toggle_done: xfers=%0d done=%b pass=%0d, required 4 1 1", k, done, pass_cnt);
        end
        tick();
    endtask

    task automatic test_gap();
        logic [6:0] exp_v = 7'b1001001;
        int beat = 0;
        rdy = 1'b1;
        start_run(32'h200, 32'd3, 8'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (valid !== exp_v[6 - i] || (exp_v[6 - i] && addr !== 32'h200 + beat) || done !== 1'b0) begin
                errors++;
                $display("FAIL gap_c%0d: valid=%b addr=%h done=%b, required %b %h 0",
                         i, valid, addr, done, exp_v[6 - i], 32'h200 + beat);
            end
            if (exp_v[6 - i]) beat++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_done: done=%b valid=%b busy=%b, required 1 0 0", done, valid, busy);
        end
        tick();
    endtask

    task automatic test_loop_wrap();
        logic [31:0] seq [3];
        seq[0] = 32'hFFFF_FFFE; seq[1] = 32'hFFFF_FFFF; seq[2] = 32'h0000_0000;
        rdy = 1'b1;
        start_run(32'hFFFF_FFFE, 32'd3, 8'd0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (valid !== 1'b1 || addr !== seq[i % 3] || last !== (i % 3 == 2) ||
                pass_cnt !== 16'(i / 3) || done !== 1'b0) begin
                errors++;
                $display("FAIL loop_c%0d: valid=%b addr=%h last=%b pass=%0d done=%b, required 1 %h %b %0d 0",
                         i, valid, addr, last, pass_cnt, done, seq[i % 3], (i % 3 == 2), i / 3);
            end
            tick();
        end
        rdy  = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || pass_cnt !== 16'd2) begin
            errors++;
            $display("FAIL loop_stop: busy=%b valid=%b done=%b pass=%0d, required 0 0 0 2",
                     busy, valid, done, pass_cnt);
        end
    endtask

    task automatic test_stop();
        rdy = 1'b1;
        start_run(32'h20, 32'd4, 8'd0, 1'b0);
        tick();
        rdy  = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || pass_cnt !== 16'd0 || addr !== 32'h21) begin
            errors++;
            $display("FAIL stop_mid: busy=%b valid=%b done=%b pass=%0d addr=%h, required 0 0 0 0 00000021",
                     busy, valid, done, pass_cnt, addr);
        end
        tick();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_mid_after: done=%b valid=%b, required 0 0", done, valid);
        end
        rdy = 1'b1;
        start_run(32'h30, 32'd2, 8'd0, 1'b0);
        tick();
        stop = 1'b1;
        checks++;
        if (last !== 1'b1 || addr !== 32'h31) begin
            errors++;
            $display("FAIL stop_last_pre: last=%b addr=%h, required 1 00000031", last, addr);
        end
        tick();
        stop = 1'b0;
        checks++;
        if (pass_cnt !== 16'd1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_last: pass=%0d done=%b busy=%b, required 1 0 0", pass_cnt, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stop_last_after: done=%b, required 0", done);
        end
    endtask

    task automatic test_zero_length();
        rdy = 1'b1;
        start_run(32'h50, 32'd0, 8'd0, 1'b0);
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b valid=%b busy=%b, required 1 0 0", done, valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: done=%b valid=%b, required 0 0", done, valid);
        end
    endtask

    task automatic test_async_reset();
        rdy = 1'b1;
        start_run(32'h55, 32'd2, 8'd0, 1'b1);
        tick(); tick(); tick();
        checks++;
        if (pass_cnt !== 16'd1 || addr !== 32'h56 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: pass=%0d addr=%h busy=%b, required 1 00000056 1", pass_cnt, addr, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({addr, valid, last, busy, done, pass_cnt} !== 52'h0) begin
            errors++;
            $display("FAIL areset: addr=%h valid=%b last=%b busy=%b done=%b pass=%0d, required all zero",
                     addr, valid, last, busy, done, pass_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back_start();
        logic [4:0] exp_v = 5'b10101;
        int beat = 0;
        rdy = 1'b1;
        start_run(32'h40, 32'd3, 8'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            base_addr = 32'h80; length = 32'd7; gap_cycles = 8'd0; loop_en = 1'b1;
            start = (i == 1 || i == 2);
            checks++;
            if (valid !== exp_v[4 - i] || (exp_v[4 - i] && addr !== 32'h40 + beat)) begin
                errors++;
                $display("FAIL busy_start_c%0d: valid=%b addr=%h, required %b %h",
                         i, valid, addr, exp_v[4 - i], 32'h40 + beat);
            end
            if (exp_v[4 - i]) beat++;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 16'd1 || addr !== 32'h42) begin
            errors++;
            $display("FAIL busy_start_done: done=%b busy=%b pass=%0d addr=%h, required 1 0 1 00000042",
                     done, busy, pass_cnt, addr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdy_toggle();
        test_gap();
        test_loop_wrap();
        test_stop();
        test_zero_length();
        test_async_reset();
        test_back_to_back_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, required finish");
        $fatal(1);
    end

endmodule
